overlap_add_address_manager: RTL and testbench
==============================================

OVERLAP_ADD_ADDRESS_MANAGER -- requirements
Module: overlap_add_address_manager

Interface
REQ-001 SHALL have parameter ADDRWIDTH, default 12, meaning window length N = 2**ADDRWIDTH with hop N/2; legal range 3..16.
REQ-002 SHALL have parameter DATAWIDTH, default 16, meaning signed two's-complement sample width.
REQ-003 SHALL have port clock  input  1  rising-edge clock.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports in_valid input 1, in_ready output 1, in_data input DATAWIDTH, for processed window samples in window order.
REQ-006 SHALL have ports out_valid output 1, out_ready input 1, out_data output DATAWIDTH, out_last output 1, for overlap-added output samples.
REQ-007 SHALL have port window_addr  output  ADDRWIDTH  index within the current window of the next accepted sample.
REQ-008 SHALL have RAM ports rd_addr output ADDRWIDTH, rd_en output 1, rd_data input DATAWIDTH (valid one cycle after rd_en), wr_addr output ADDRWIDTH, wr_en output 1, wr_data output DATAWIDTH.

Function
REQ-009 SHALL treat RAM as two halves; register cur (1 bit) selects the half accumulating the current window's first half.
REQ-010 SHALL accept an input when in_valid && in_ready, then increment window_addr modulo N; on wrap, toggle cur.
REQ-011 SHALL, for accepted sample with window_addr < N/2, read {cur, window_addr[ADDRWIDTH-2:0]} in the accept cycle and write rd_data + in_data to the same address one cycle later.
REQ-012 SHALL, while flag first is set, write in_data without the read/add for window_addr < N/2; first clears on the first window wrap.
REQ-013 SHALL, for window_addr >= N/2, write in_data to {~cur, window_addr[ADDRWIDTH-2:0]} one cycle after acceptance, issuing no read.
REQ-014 SHALL set drain_busy when the write for window_addr = N/2-1 completes; drain emits half cur, addresses 0..N/2-1 in order, then clears drain_busy.
REQ-015 SHALL deassert in_ready when window_addr >= N/2 and drain_busy targets half ~cur; otherwise in_ready = 1.
REQ-016 SHALL share the read port: an accumulator read has priority; a drain read issues only in cycles without an accumulator read.
REQ-017 SHALL hold drained data in a 2-entry skid buffer; a drain read issues only if buffer occupancy plus reads in flight < 2.
REQ-018 SHALL present out_data from the skid head; an output transfers on out_valid && out_ready; out_last = 1 on sample N/2-1 of each drained half.
REQ-019 SHALL never assert rd_en or wr_en for two addresses in one cycle per port, and never drop or duplicate samples under any in_valid/out_ready pattern.

Reset
REQ-020 SHALL, when reset_n = 0 at a rising edge: window_addr = 0, cur = 0, first = 1, drain_busy = 0, skid empty, out_valid = 0, out_last = 0, rd_en = 0, wr_en = 0, in_ready = 1.
REQ-021 SHALL discard in-flight reads and pending writes on reset mid-operation; RAM contents are not cleared.

Configuration
REQ-022 SHALL, with macro OLA_SATURATE_EN defined, clamp the REQ-011 sum to [-2**(DATAWIDTH-1), 2**(DATAWIDTH-1)-1].
REQ-023 SHALL, without OLA_SATURATE_EN, compute the sum modulo 2**DATAWIDTH (wrap-around).

Verification (ADDRWIDTH=3, DATAWIDTH=16)
REQ-024 SHALL cover: reset, two windows of in_data=1, out_ready=1 -> out_data 1,1,1,1,2,2,2,2, out_last on 4th and 8th outputs.
REQ-025 SHALL cover: out_ready=0 from window 0 drain start -> in_ready=0 at window 1 window_addr=4; out_ready=1 -> drain completes, window 1 resumes, no loss.
REQ-026 SHALL cover: 0x7000 in both overlapping halves -> 0x7FFF with OLA_SATURATE_EN, 0xE000 without.
REQ-027 SHALL cover: reset_n=0 at window_addr=5 with drain pending -> next cycle out_valid=0, window_addr=0; next first half written without add.
REQ-028 SHALL cover: continuous in_valid, random out_ready -> rd_en never double-booked, output sequence equals golden overlap-add model.

Source files
------------

// File: rtl/overlap_add_address_manager.sv
// rtl/overlap_add_address_manager.sv - overlap-add accumulation RAM sequencer with drain skid buffer
// Optional OLA_SATURATE_EN: clamp accumulated sums instead of wrapping them.
module overlap_add_address_manager #(
  parameter int ADDRWIDTH = 12,
  parameter int DATAWIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] out_data,
  output logic                 out_last,
  output logic [ADDRWIDTH-1:0] window_addr,
  output logic [ADDRWIDTH-1:0] rd_addr,
  output logic                 rd_en,
  input  logic [DATAWIDTH-1:0] rd_data,
  output logic [ADDRWIDTH-1:0] wr_addr,
  output logic                 wr_en,
  output logic [DATAWIDTH-1:0] wr_data
);
  localparam int HW = ADDRWIDTH - 1;
  localparam logic [HW-1:0] HALF_LAST = '1;

  logic [ADDRWIDTH-1:0] waddr_q, waddr_d;
  logic                 cur_q, cur_d;
  logic                 first_q, first_d;

  logic                 wr_pend_q, wr_add_q, wr_fin_q;
  logic [ADDRWIDTH-1:0] wr_addr_q;
  logic [DATAWIDTH-1:0] wr_in_q;

  logic                 drain_busy_q, drain_busy_d;
  logic                 drain_half_q, drain_half_d;
  logic [HW-1:0]        drain_idx_q, drain_idx_d;
  logic                 pend_q, pend_d;
  logic                 pend_half_q, pend_half_d;

  logic                 fly_q, fly_last_q;
  logic [DATAWIDTH-1:0] skid_data_q [2];
  logic [1:0]           skid_last_q;
  logic                 skid_rp_q, skid_wp_q;
  logic [1:0]           skid_cnt_q, skid_cnt_d;

  logic                 upper, accept, acc_rd, drain_rd, drain_done, push, pop;
  logic [HW-1:0]        in_idx;
  logic [DATAWIDTH-1:0] sum_res;

  assign in_idx   = waddr_q[HW-1:0];
  assign upper    = waddr_q[ADDRWIDTH-1];
  // Second-half writes target ~cur; they must wait until that half has been read out.
  assign in_ready = !(upper && drain_busy_q && (drain_half_q != cur_q));
  assign accept   = in_valid && in_ready;
  assign acc_rd   = accept && !upper && !first_q;

  assign drain_rd   = drain_busy_q && !acc_rd &&
                      (({1'b0, skid_cnt_q} + {2'b00, fly_q}) < 3'd2);
  assign drain_done = drain_rd && (drain_idx_q == HALF_LAST);

  assign rd_en   = acc_rd || drain_rd;
  assign rd_addr = acc_rd ? {cur_q, in_idx} : {drain_half_q, drain_idx_q};

  assign push = fly_q;
  assign pop  = out_valid && out_ready;

  assign out_valid   = (skid_cnt_q != 2'd0);
  assign out_data    = skid_data_q[skid_rp_q];
  assign out_last    = out_valid && skid_last_q[skid_rp_q];
  assign window_addr = waddr_q;

`ifdef OLA_SATURATE_EN
  logic [DATAWIDTH:0] sum_full;
  assign sum_full = {rd_data[DATAWIDTH-1], rd_data} + {wr_in_q[DATAWIDTH-1], wr_in_q};
  always_comb begin
    sum_res = sum_full[DATAWIDTH-1:0];
    if (sum_full[DATAWIDTH] != sum_full[DATAWIDTH-1])
      sum_res = {sum_full[DATAWIDTH], {(DATAWIDTH-1){~sum_full[DATAWIDTH]}}};
  end
`else
  assign sum_res = rd_data + wr_in_q;
`endif

  assign wr_en   = wr_pend_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_add_q ? sum_res : wr_in_q;

  always_comb begin
    waddr_d = waddr_q;
    cur_d   = cur_q;
    first_d = first_q;
    if (accept) begin
      waddr_d = waddr_q + ADDRWIDTH'(1);
      if (waddr_q == '1) begin
        cur_d   = ~cur_q;
        first_d = 1'b0;
      end
    end
  end

  // A finished first half may arrive while the previous half is still draining; it queues in pend.
  always_comb begin
    drain_busy_d = drain_busy_q;
    drain_half_d = drain_half_q;
    drain_idx_d  = drain_idx_q;
    pend_d       = pend_q;
    pend_half_d  = pend_half_q;
    if (drain_rd) begin
      drain_idx_d = drain_idx_q + HW'(1);
      if (drain_done) drain_busy_d = 1'b0;
    end
    if (!drain_busy_d && pend_q) begin
      drain_busy_d = 1'b1;
      drain_half_d = pend_half_q;
      drain_idx_d  = '0;
      pend_d       = 1'b0;
    end
    if (wr_pend_q && wr_fin_q) begin
      if (drain_busy_d) begin
        pend_d      = 1'b1;
        pend_half_d = wr_addr_q[ADDRWIDTH-1];
      end else begin
        drain_busy_d = 1'b1;
        drain_half_d = wr_addr_q[ADDRWIDTH-1];
        drain_idx_d  = '0;
      end
    end
  end

  always_comb begin
    skid_cnt_d = skid_cnt_q;
    if (push && !pop)      skid_cnt_d = skid_cnt_q + 2'd1;
    else if (pop && !push) skid_cnt_d = skid_cnt_q - 2'd1;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      waddr_q      <= '0;
      cur_q        <= 1'b0;
      first_q      <= 1'b1;
      wr_pend_q    <= 1'b0;
      wr_add_q     <= 1'b0;
      wr_fin_q     <= 1'b0;
      drain_busy_q <= 1'b0;
      drain_half_q <= 1'b0;
      drain_idx_q  <= '0;
      pend_q       <= 1'b0;
      pend_half_q  <= 1'b0;
      fly_q        <= 1'b0;
      fly_last_q   <= 1'b0;
      skid_rp_q    <= 1'b0;
      skid_wp_q    <= 1'b0;
      skid_cnt_q   <= 2'd0;
    end else begin
      waddr_q      <= waddr_d;
      cur_q        <= cur_d;
      first_q      <= first_d;
      wr_pend_q    <= accept;
      wr_add_q     <= acc_rd;
      wr_fin_q     <= accept && !upper && (in_idx == HALF_LAST);
      drain_busy_q <= drain_busy_d;
      drain_half_q <= drain_half_d;
      drain_idx_q  <= drain_idx_d;
      pend_q       <= pend_d;
      pend_half_q  <= pend_half_d;
      fly_q        <= drain_rd;
      fly_last_q   <= drain_done;
      skid_cnt_q   <= skid_cnt_d;
      if (push) skid_wp_q <= ~skid_wp_q;
      if (pop)  skid_rp_q <= ~skid_rp_q;
    end
  end

  always_ff @(posedge clock) begin
    wr_addr_q <= {upper ^ cur_q, in_idx};
    wr_in_q   <= in_data;
    if (push) begin
      skid_data_q[skid_wp_q] <= rd_data;
      skid_last_q[skid_wp_q] <= fly_last_q;
    end
  end

endmodule

// File: tb/tb_overlap_add_address_manager.sv
// tb/tb_overlap_add_address_manager.sv - self-checking bench for overlap_add_address_manager
// Compile with OLA_SATURATE_EN defined to check the saturating build.
module tb_overlap_add_address_manager;
  localparam int AW = 3;
  localparam int DW = 16;
  localparam int N  = 8;
  localparam int H  = 4;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic [AW-1:0] window_addr;
  logic [AW-1:0] rd_addr;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] wr_addr;
  logic          wr_en;
  logic [DW-1:0] wr_data;

  logic [DW-1:0] ram [N];

  int tests = 0;
  int fails = 0;
  int feed_i = 0;
  logic [15:0] feed_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  logic        exp_last_q[$];
  logic        got_last_q[$];

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] lo;
    logic [15:0] hi_wrap;
    logic [15:0] hi_sat;
  } vec_t;
  vec_t vecs[4];

  overlap_add_address_manager #(.ADDRWIDTH(AW), .DATAWIDTH(DW)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .window_addr(window_addr),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
    .wr_addr(wr_addr), .wr_en(wr_en), .wr_data(wr_data)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (wr_en) ram[wr_addr] <= wr_data;
    if (rd_en) rd_data <= ram[rd_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ola_add(input logic [15:0] a, input logic [15:0] b);
    int s;
    s = int'(signed'(a)) + int'(signed'(b));
`ifdef OLA_SATURATE_EN
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
`endif
    return s[15:0];
  endfunction

  // Golden overlap-add: output half h = first half of window h + second half of window h-1.
  task automatic build_expect(input int nwin);
    exp_q.delete();
    exp_last_q.delete();
    for (int h = 0; h < nwin; h++) begin
      for (int j = 0; j < H; j++) begin
        logic [15:0] v;
        v = (h == 0) ? feed_q[h*N+j] : ola_add(feed_q[h*N+j], feed_q[(h-1)*N+H+j]);
        exp_q.push_back(v);
        exp_last_q.push_back(j == H-1);
      end
    end
  endtask

  task automatic reset_dut();
    reset_n  = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    feed_q.delete();
    got_q.delete();
    got_last_q.delete();
    feed_i = 0;
  endtask

  task automatic cycle();
    int exp_addr;
    in_valid = (feed_i < feed_q.size());
    in_data  = in_valid ? feed_q[feed_i] : 16'h0;
    @(negedge clock);
    if (in_valid && in_ready) begin
      check("window_addr_seq", window_addr, feed_i % N);
      if (!window_addr[AW-1]) begin
        if (feed_i >= N) begin
          exp_addr = ((feed_i / N) % 2) * H + (feed_i % N);
          check("acc_rd_en", rd_en, 1);
          check("acc_rd_addr", rd_addr, exp_addr);
        end else begin
          check("first_no_rd", rd_en, 0);
        end
      end
      feed_i++;
    end
    if (out_valid && out_ready) begin
      got_q.push_back(out_data);
      got_last_q.push_back(out_last);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic run_done(input int budget, input bit rnd, input string name);
    int n = 0;
    while ((feed_i < feed_q.size() || got_q.size() < exp_q.size()) && n < budget) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cycle();
      n++;
    end
    if (n >= budget) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got %0d outputs expected %0d", name, got_q.size(), exp_q.size());
    end
    out_ready = 1'b1;
    repeat (6) cycle();
    in_valid = 1'b0;
  endtask

  task automatic compare(input string name);
    check({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s_data[%0d]", name, i), got_q[i], exp_q[i]);
      check($sformatf("%s_last[%0d]", name, i), got_last_q[i], exp_last_q[i]);
    end
  endtask

  initial begin
    int n;
    logic [15:0] hi;
    vecs[0] = '{16'h0001, 16'h0001, 16'h0001, 16'h0002, 16'h0002};
    vecs[1] = '{16'h7000, 16'h7000, 16'h7000, 16'hE000, 16'h7FFF};
    vecs[2] = '{16'h8000, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h8000};
    vecs[3] = '{16'h0005, 16'hFFFD, 16'h0005, 16'h0002, 16'h0002};

    reset_dut();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_window_addr", window_addr, 0);

    foreach (vecs[v]) begin
      reset_dut();
      for (int i = 0; i < 2*N; i++) feed_q.push_back(i < N ? vecs[v].a : vecs[v].b);
`ifdef OLA_SATURATE_EN
      hi = vecs[v].hi_sat;
`else
      hi = vecs[v].hi_wrap;
`endif
      exp_q.delete();
      exp_last_q.delete();
      for (int i = 0; i < 2*H; i++) begin
        exp_q.push_back(i < H ? vecs[v].lo : hi);
        exp_last_q.push_back((i % H) == H-1);
      end
      run_done(200, 1'b0, $sformatf("vec%0d", v));
      compare($sformatf("vec%0d", v));
    end

    // Back-pressure from the start of the first drain stalls window 1 at its second half.
    reset_dut();
    for (int i = 0; i < 2*N; i++) feed_q.push_back(16'($urandom));
    build_expect(2);
    out_ready = 1'b0;
    n = 0;
    while (feed_i < 12 && n < 100) begin cycle(); n++; end
    check("stall_in_ready", in_ready, 0);
    check("stall_window_addr", window_addr, 4);
    repeat (3) cycle();
    check("stall_hold", feed_i, 12);
    check("stall_out_valid", out_valid, 1);
    run_done(300, 1'b0, "stall");
    compare("stall");

    // Reset in the middle of window 1 while its first half is draining.
    reset_dut();
    for (int i = 0; i < N + 5; i++) feed_q.push_back(16'($urandom_range(1, 16'hFFFF)));
    out_ready = 1'b1;
    n = 0;
    while (feed_i < N + 5 && n < 100) begin cycle(); n++; end
    check("pre_rst_window_addr", window_addr, 5);
    reset_n  = 1'b0;
    in_valid = 1'b0;
    @(posedge clock);
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_window_addr", window_addr, 0);
    check("mid_rst_wr_en", wr_en, 0);
    reset_n = 1'b1;
    feed_q.delete();
    got_q.delete();
    got_last_q.delete();
    feed_i = 0;
    for (int i = 0; i < N; i++) feed_q.push_back(16'($urandom_range(1, 16'hFFFF)));
    build_expect(1);
    run_done(100, 1'b0, "post_rst");
    compare("post_rst");

    // Continuous input with random output back-pressure against the golden model.
    for (int r = 0; r < 2; r++) begin
      reset_dut();
      for (int i = 0; i < 6*N; i++)
        feed_q.push_back(($urandom_range(0, 3) == 0) ? 16'(16'h7000 + $urandom_range(0, 255))
                                                      : 16'($urandom));
      build_expect(6);
      run_done(3000, 1'b1, $sformatf("rand%0d", r));
      compare($sformatf("rand%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
